// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_pkg
// Description : Shared definitions for the debug write port. Mode and select
//               encodings are the same ones the state observer decodes, so a
//               debug host uses a single address map for reads and writes.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_pkg;

    // Bus widths, kept in step with the core's bus definitions
    localparam int REG_ADDR_W  = 4;   // RegAddrBus
    localparam int REG_W       = 32;  // RegBus
    localparam int INST_ADDR_W = 32;  // InstAddrBus
    localparam int INST_W      = 32;  // InstBus

    // Target class encodings
    localparam logic [1:0] DBG_MODE_REG = 2'b00;
    localparam logic [1:0] DBG_MODE_SPC = 2'b11;

    // Special-register selects within DBG_MODE_SPC
    localparam logic [REG_ADDR_W-1:0] DBG_SEL_PC = 4'b1110;
    localparam logic [REG_ADDR_W-1:0] DBG_SEL_IR = 4'b1111;

    // Writer FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HALT_WAIT = 3'd1,
        ST_WRITE     = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_DONE      = 3'd4
    } dbg_state_e;

    // A command is legal for any regfile index, or for PC/IR in special mode
    function automatic logic dbg_cmd_legal(input logic [1:0]            mode,
                                           input logic [REG_ADDR_W-1:0] sel);
        return (mode == DBG_MODE_REG) ||
               ((mode == DBG_MODE_SPC) && ((sel == DBG_SEL_PC) || (sel == DBG_SEL_IR)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_timeout.sv
`default_nettype none
// ============================================================================
// Module      : dbg_timeout
// Description : Clearable, enabled cycle counter bounding the halt handshake.
//               expired_o fires on the cycle whose increment would land on
//               HALT_TIMEOUT, so a waiting state lasts exactly HALT_TIMEOUT
//               cycles before it gives up.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_timeout #(
    parameter int HALT_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = (HALT_TIMEOUT < 1) ? 1 : $clog2(HALT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over count so a state change always restarts the window
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i & (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/debug_writer.sv
`default_nettype none
// ============================================================================
// Module      : debug_writer
// Description : Debug write port. Accepts one command, halts the core via
//               halt_req/halt_ack, issues a single-cycle strobe into the
//               regfile, PC or IR, releases the core and reports completion.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_writer
    import debug_pkg::*;
#(
    parameter int HALT_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_mode_i,
    input  logic [REG_ADDR_W-1:0]  cmd_sel_i,
    input  logic [REG_W-1:0]       cmd_data_i,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   halt_req_o,
    input  logic                   halt_ack_i,
    output logic                   reg_we_o,
    output logic [REG_ADDR_W-1:0]  reg_waddr_o,
    output logic [REG_W-1:0]       reg_wdata_o,
    output logic                   pc_we_o,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic                   ir_we_o,
    output logic [INST_W-1:0]      ir_o
);

    dbg_state_e            state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [REG_ADDR_W-1:0] sel_q, sel_d;
    logic [REG_W-1:0]      data_q, data_d;
    logic                  err_q, err_d;

    logic w_accept;
    logic w_legal;
    logic w_tmo_clr;
    logic w_tmo_en;
    logic w_tmo_expired;

    assign w_accept = cmd_valid_i & (state_q == ST_IDLE);
    assign w_legal  = dbg_cmd_legal(cmd_mode_i, cmd_sel_i);

    // Window restarts on every state change; it only counts while waiting on ack
    assign w_tmo_clr = (state_d != state_q);
    assign w_tmo_en  = (state_q == ST_HALT_WAIT) || (state_q == ST_RELEASE);

    dbg_timeout #(
        .HALT_TIMEOUT(HALT_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (w_tmo_clr),
        .en_i      (w_tmo_en),
        .expired_o (w_tmo_expired)
    );

    // State register; async reset drops halt_req at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ack takes priority over a simultaneous timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = w_legal ? ST_HALT_WAIT : ST_DONE;
                end
            end
            ST_HALT_WAIT: begin
                if (halt_ack_i) begin
                    state_d = ST_WRITE;
                end else if (w_tmo_expired) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_WRITE:   state_d = ST_RELEASE;
            ST_RELEASE: begin
                if (!halt_ack_i || w_tmo_expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state only
    always_comb begin
        cmd_ready_o = 1'b0;
        halt_req_o  = 1'b0;
        reg_we_o    = 1'b0;
        pc_we_o     = 1'b0;
        ir_we_o     = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (state_q)
            ST_IDLE:      cmd_ready_o = 1'b1;
            ST_HALT_WAIT: halt_req_o  = 1'b1;
            ST_WRITE: begin
                halt_req_o = 1'b1;
                reg_we_o   = (mode_q == DBG_MODE_REG);
                pc_we_o    = (mode_q == DBG_MODE_SPC) && (sel_q == DBG_SEL_PC);
                ir_we_o    = (mode_q == DBG_MODE_SPC) && (sel_q == DBG_SEL_IR);
            end
            ST_RELEASE:   ;
            ST_DONE: begin
                done_o = 1'b1;
                err_o  = err_q;
            end
            default:      ;
        endcase
    end

    // Command latch and sticky error flag for the command in flight
    always_comb begin
        mode_d = mode_q;
        sel_d  = sel_q;
        data_d = data_q;
        err_d  = err_q;
        if (w_accept) begin
            mode_d = cmd_mode_i;
            sel_d  = cmd_sel_i;
            data_d = cmd_data_i;
            err_d  = ~w_legal;
        end
        if ((state_q == ST_HALT_WAIT) && !halt_ack_i && w_tmo_expired) begin
            err_d = 1'b1;
        end
        if ((state_q == ST_RELEASE) && halt_ack_i && w_tmo_expired) begin
            err_d = 1'b1;
        end
        if (state_q == ST_DONE) begin
            err_d = 1'b0;
        end
    end

    // Command latch registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
            sel_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            sel_q  <= sel_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    // Address/data buses are the latched command; strobes qualify them
    assign reg_waddr_o = sel_q;
    assign reg_wdata_o = data_q;
    assign pc_o        = data_q;
    assign ir_o        = data_q;

endmodule
`default_nettype wire
